mvm_job_sched: RTL and testbench

- Sequences the 4-lane stochastic MVM datapath over a multi-step job: fetches one (x-group, w) operand per step, pulses MVM start, waits out the busy window and samples the 4-bit lane results.
- Accumulates the 4-bit lane results into wide saturating per-lane partial sums and returns them through a valid/ready result port.
- Sits between the layer-level buffer/control logic and one MVM instance.

---
 rtl/mvm_pkg.sv | 19 +
 rtl/sat_acc_lane.sv | 47 ++++
 rtl/mvm_job_sched.sv | 179 +++++++++++++++++
 tb/tb_mvm_job_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types for the stochastic MVM datapath and its job scheduler.
package mvm_pkg;

    localparam int LANES = 4;
    localparam int XW    = 4;

    typedef logic [XW-1:0] nib_t;
    typedef nib_t [LANES-1:0] nib_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        WAIT_BUSY,
        RUN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/sat_acc_lane.sv
// One lane of the job accumulator: sign-extends a 4-bit MVM result and adds it
// into a saturating ACC_W-bit two's-complement partial sum.
module sat_acc_lane
    import mvm_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic             i_clk_udc,
    input  logic             i_rst_udc,
    input  logic             clr,
    input  logic             en,
    input  logic [XW-1:0]    res,
    output logic [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] acc_q;

    // One guard bit catches overflow; clamp instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic        [XW-1:0]    b
    );
        logic signed [ACC_W:0] a_ext;
        logic signed [ACC_W:0] b_ext;
        logic signed [ACC_W:0] sum;
        a_ext = {a[ACC_W-1], a};
        b_ext = {{(ACC_W + 1 - XW){b[XW-1]}}, b};
        sum   = a_ext + b_ext;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return sum[ACC_W-1:0];
    endfunction

    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sat_add(acc_q, res);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mvm_job_sched.sv
// Job scheduler for one 4-lane stochastic MVM: fetches operands step by step,
// pulses start, samples lane results once busy falls, and returns the sums.
module mvm_job_sched
    import mvm_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 16
) (
    input  logic                   i_clk_udc,
    input  logic                   i_rst_udc,
    input  logic                   i_abort,
    input  logic                   i_job_valid,
    output logic                   o_job_ready,
    input  logic [LEN_W-1:0]       i_job_len,
    input  logic                   i_op_valid,
    output logic                   o_op_ready,
    input  logic [LANES*XW-1:0]    i_op_x,
    input  logic [XW-1:0]          i_op_w,
    output logic                   o_mvm_start,
    output logic [LANES*XW-1:0]    o_mvm_x,
    output logic [XW-1:0]          o_mvm_w,
    input  logic                   i_mvm_busy,
    input  logic [LANES*XW-1:0]    i_mvm_res,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [LANES*ACC_W-1:0] o_res_acc,
    output logic                   o_res_err,
    output logic                   o_busy
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    sched_state_t     state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] step_q;
    logic [TMR_W-1:0] tmr_q;
    nib_vec_t         x_q;
    nib_t             w_q;
    logic             err_q;
    nib_vec_t         res_vec;

    logic ld_job, ld_op, tmr_clr, tmr_inc, set_err, acc_en, acc_clr;

    always_comb begin
        state_d = state_q;
        ld_job  = 1'b0;
        ld_op   = 1'b0;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        set_err = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_job_valid) begin
                    ld_job  = 1'b1;
                    state_d = (i_job_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (i_op_valid) begin
                    ld_op   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tmr_clr = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_mvm_busy) begin
                    state_d = RUN;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            RUN: begin
                // The datapath clears its counters one cycle after busy falls,
                // so the first low-busy cycle is the only valid sample.
                if (!i_mvm_busy) begin
                    acc_en  = 1'b1;
                    state_d = (step_q == len_q - LEN_W'(1)) ? DONE : FETCH;
                end
            end
            DONE: begin
                if (i_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_abort) begin
            state_d = IDLE;
            ld_job  = 1'b0;
            ld_op   = 1'b0;
            tmr_clr = 1'b0;
            tmr_inc = 1'b0;
            set_err = 1'b0;
            acc_en  = 1'b0;
        end
    end

    assign acc_clr = i_abort | ld_job;

    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            len_q  <= '0;
            step_q <= '0;
            tmr_q  <= '0;
            x_q    <= '0;
            w_q    <= '0;
            err_q  <= 1'b0;
        end else if (i_abort) begin
            len_q  <= '0;
            step_q <= '0;
            tmr_q  <= '0;
            x_q    <= '0;
            w_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (ld_job) begin
                len_q  <= i_job_len;
                step_q <= '0;
                err_q  <= 1'b0;
            end
            if (ld_op) begin
                x_q <= i_op_x;
                w_q <= i_op_w;
            end
            if (tmr_clr) begin
                tmr_q <= '0;
            end else if (tmr_inc) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (acc_en) begin
                step_q <= step_q + LEN_W'(1);
            end
        end
    end

    assign res_vec = i_mvm_res;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sat_acc_lane #(
            .ACC_W(ACC_W)
        ) u_lane (
            .i_clk_udc(i_clk_udc),
            .i_rst_udc(i_rst_udc),
            .clr      (acc_clr),
            .en       (acc_en),
            .res      (res_vec[l]),
            .acc      (o_res_acc[l*ACC_W +: ACC_W])
        );
    end

    assign o_job_ready = (state_q == IDLE);
    assign o_op_ready  = (state_q == FETCH);
    assign o_mvm_start = (state_q == START);
    assign o_res_valid = (state_q == DONE);
    assign o_busy      = (state_q != IDLE);
    assign o_mvm_x     = x_q;
    assign o_mvm_w     = w_q;
    assign o_res_err   = err_q;

endmodule

// File: tb/tb_mvm_job_sched.sv
// Directed-plus-random bench for mvm_job_sched with a behavioural MVM stand-in
// and a lane-sum reference model.
module tb_mvm_job_sched;

    localparam int ACC_W   = 8;
    localparam int LEN_W   = 6;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   i_rst_udc;
    logic                   i_abort;
    logic                   i_job_valid;
    logic                   o_job_ready;
    logic [LEN_W-1:0]       i_job_len;
    logic                   i_op_valid;
    logic                   o_op_ready;
    logic [15:0]            i_op_x;
    logic [3:0]             i_op_w;
    logic                   o_mvm_start;
    logic [15:0]            o_mvm_x;
    logic [3:0]             o_mvm_w;
    logic                   i_mvm_busy;
    logic [15:0]            i_mvm_res;
    logic                   o_res_valid;
    logic                   i_res_ready;
    logic [4*ACC_W-1:0]     o_res_acc;
    logic                   o_res_err;
    logic                   o_busy;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int model [4];

    mvm_job_sched #(.ACC_W(ACC_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk_udc  (clk),
        .i_rst_udc  (i_rst_udc),
        .i_abort    (i_abort),
        .i_job_valid(i_job_valid),
        .o_job_ready(o_job_ready),
        .i_job_len  (i_job_len),
        .i_op_valid (i_op_valid),
        .o_op_ready (o_op_ready),
        .i_op_x     (i_op_x),
        .i_op_w     (i_op_w),
        .o_mvm_start(o_mvm_start),
        .o_mvm_x    (o_mvm_x),
        .o_mvm_w    (o_mvm_w),
        .i_mvm_busy (i_mvm_busy),
        .i_mvm_res  (i_mvm_res),
        .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready),
        .o_res_acc  (o_res_acc),
        .o_res_err  (o_res_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_mvm_start === 1'b1) start_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        int hi = (1 << (ACC_W - 1)) - 1;
        int lo = -(1 << (ACC_W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_clear;
        for (int l = 0; l < 4; l++) model[l] = 0;
    endtask

    task automatic chk_acc(input string tag);
        logic [31:0] e;
        for (int l = 0; l < 4; l++) begin
            e = 32'(model[l]);
            chk($sformatf("%s_lane%0d", tag, l), 32'(o_res_acc[l*ACC_W +: ACC_W]), {24'd0, e[ACC_W-1:0]});
        end
    endtask

    task automatic check_result(input string tag, input logic exp_err);
        chk({tag, "_valid"}, o_res_valid, 1);
        chk({tag, "_err"}, o_res_err, exp_err);
        chk({tag, "_job_ready"}, o_job_ready, 0);
        chk_acc(tag);
    endtask

    task automatic accept_job(input int len);
        chk("job_ready_idle", o_job_ready, 1);
        model_clear();
        i_job_valid = 1'b1;
        i_job_len   = LEN_W'(len);
        tick;
        i_job_valid = 1'b0;
        i_job_len   = LEN_W'($urandom);
    endtask

    task automatic finish_result(input string tag, input int hold);
        i_job_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, "_hold_valid"}, o_res_valid, 1);
            chk({tag, "_hold_job_ready"}, o_job_ready, 0);
            chk_acc({tag, "_hold"});
        end
        i_res_ready = 1'b1;
        tick;
        i_res_ready = 1'b0;
        chk({tag, "_released_valid"}, o_res_valid, 0);
        chk({tag, "_released_job_ready"}, o_job_ready, 1);
    endtask

    // mode: 0 normal step, 1 busy never rises, 2 abort in RUN, 3 async reset in WAIT_BUSY
    task automatic do_step(input logic [15:0] res, input int stall, input int dly,
                           input int blen, input int mode);
        logic [15:0] x;
        logic [3:0]  w;
        i_job_valid = 1'($urandom);
        i_job_len   = LEN_W'($urandom);
        for (int i = 0; i < stall; i++) begin
            chk("stall_no_start", o_mvm_start, 0);
            tick;
        end
        chk("op_ready", o_op_ready, 1);
        x = 16'($urandom);
        w = 4'($urandom);
        i_op_valid = 1'b1;
        i_op_x     = x;
        i_op_w     = w;
        tick;
        i_op_valid = 1'b0;
        i_op_x     = ~x;
        i_op_w     = ~w;
        chk("start_pulse", o_mvm_start, 1);
        chk("mvm_x", o_mvm_x, x);
        chk("mvm_w", o_mvm_w, w);
        tick;
        chk("start_one_cycle", o_mvm_start, 0);
        if (mode == 1) begin
            repeat (TIMEOUT - 1) tick;
            chk("timeout_not_yet", o_res_valid, 0);
            tick;
            return;
        end
        if (mode == 3) begin
            tick;
            #2 i_rst_udc = 1'b1;
            #1;
            chk("arst_busy", o_busy, 0);
            chk("arst_job_ready", o_job_ready, 1);
            chk("arst_valid", o_res_valid, 0);
            chk("arst_start", o_mvm_start, 0);
            chk("arst_mvm_x", o_mvm_x, 0);
            chk("arst_mvm_w", o_mvm_w, 0);
            chk("arst_err", o_res_err, 0);
            model_clear();
            chk_acc("arst_acc");
            @(posedge clk);
            #1;
            i_rst_udc   = 1'b0;
            i_job_valid = 1'b0;
            return;
        end
        repeat (dly) tick;
        i_mvm_busy = 1'b1;
        tick;
        if (mode == 2) begin
            tick;
            i_abort = 1'b1;
            tick;
            i_abort     = 1'b0;
            i_mvm_busy  = 1'b0;
            i_job_valid = 1'b0;
            chk("abort_job_ready", o_job_ready, 1);
            chk("abort_busy", o_busy, 0);
            chk("abort_valid", o_res_valid, 0);
            chk("abort_mvm_x", o_mvm_x, 0);
            model_clear();
            chk_acc("abort_acc");
            tick;
            chk("abort_no_result", o_res_valid, 0);
            return;
        end
        repeat (blen - 1) tick;
        chk("x_hold", o_mvm_x, x);
        chk("w_hold", o_mvm_w, w);
        i_mvm_busy = 1'b0;
        i_mvm_res  = res;
        tick;
        i_mvm_res = 16'($urandom);
        for (int l = 0; l < 4; l++) begin
            model[l] = sat(model[l] + int'($signed(res[4*l +: 4])));
        end
    endtask

    task automatic run_job(input string tag, input int len, input bit sat_mode, input int stall_max);
        int base;
        logic [15:0] r;
        base = start_cnt;
        accept_job(len);
        for (int s = 0; s < len; s++) begin
            r = 16'($urandom);
            if (sat_mode) r[7:0] = 8'h87;
            do_step(r, $urandom_range(0, stall_max), $urandom_range(0, 10), $urandom_range(1, 6), 0);
        end
        check_result(tag, 1'b0);
        chk({tag, "_start_count"}, 32'(start_cnt - base), 32'(len));
        finish_result(tag, $urandom_range(0, 3));
    endtask

    initial begin
        int base;
        i_rst_udc   = 1'b1;
        i_abort     = 1'b0;
        i_job_valid = 1'b0;
        i_job_len   = '0;
        i_op_valid  = 1'b0;
        i_op_x      = '0;
        i_op_w      = '0;
        i_mvm_busy  = 1'b0;
        i_mvm_res   = '0;
        i_res_ready = 1'b0;
        model_clear();
        repeat (2) tick;
        chk("rst_job_ready", o_job_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_res_valid, 0);
        chk("rst_start", o_mvm_start, 0);
        chk("rst_op_ready", o_op_ready, 0);
        chk("rst_err", o_res_err, 0);
        chk("rst_mvm_x", o_mvm_x, 0);
        chk_acc("rst_acc");
        i_rst_udc = 1'b0;
        tick;

        // Basic two-step job with operand stall and result back-pressure
        base = start_cnt;
        accept_job(2);
        do_step(16'h87E3, 5, 2, 3, 0);
        do_step(16'h81F5, 0, 0, 1, 0);
        check_result("basic", 1'b0);
        chk("basic_start_count", 32'(start_cnt - base), 2);
        finish_result("basic", 10);

        run_job("sat", 20, 1'b1, 1);

        // Empty job: result the cycle after accept, previous sums cleared
        base = start_cnt;
        accept_job(0);
        check_result("empty", 1'b0);
        finish_result("empty", 1);
        chk("empty_start_count", 32'(start_cnt - base), 0);

        // Timeout in step 2 keeps step-1 sums and flags the error
        accept_job(3);
        do_step(16'($urandom), 0, 1, 2, 0);
        do_step(16'($urandom), 0, 0, 1, 1);
        check_result("timeout", 1'b1);
        finish_result("timeout", 2);

        accept_job(2);
        do_step(16'($urandom), 0, 1, 2, 0);
        do_step(16'($urandom), 0, 1, 3, 2);

        accept_job(3);
        do_step(16'($urandom), 0, 1, 2, 0);
        do_step(16'($urandom), 0, 0, 1, 3);
        chk("post_arst_job_ready", o_job_ready, 1);

        for (int j = 0; j < 4; j++) begin
            run_job($sformatf("rand%0d", j), $urandom_range(1, 6), 1'b0, 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
